// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath:
// decoded IR fields and ALU flags in, enables/selects/ALU opcode out.
interface mc_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       pc_en;
  logic       ir_en;
  logic       iord;
  logic       mem_we;
  logic       reg_we;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic       ext_sign;
  logic [3:0] alucont;
  logic [1:0] pcsrc;
  logic [3:0] state;
  logic       exc;

  modport master (
    input  op, funct, zero, overflow,
    output pc_en, ir_en, iord, mem_we, reg_we, regdst, memtoreg,
           alusrca, alusrcb, ext_sign, alucont, pcsrc, state, exc
  );

  modport slave (
    output op, funct, zero, overflow,
    input  pc_en, ir_en, iord, mem_we, reg_we, regdst, memtoreg,
           alusrca, alusrcb, ext_sign, alucont, pcsrc, state, exc
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM. Optional overflow trap on add/sub/addi
// write-back is enabled by defining OVERFLOW_TRAP_EN.
module mc_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic         clk,
  input  logic         rst,
  mc_control_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
    S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13, S_RSV14  = 4'd14, S_RSV15 = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADDU = 4'b0000, ALU_SUBU = 4'b0001, ALU_ADD  = 4'b0010,
                         ALU_SUB  = 4'b0011, ALU_OR   = 4'b0100, ALU_AND  = 4'b0101,
                         ALU_XOR  = 4'b0110, ALU_NOR  = 4'b0111, ALU_SLTU = 4'b1000,
                         ALU_SLT  = 4'b1001, ALU_SLL  = 4'b1010, ALU_SRL  = 4'b1011,
                         ALU_SRA  = 4'b1100, ALU_LUI  = 4'b1101;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL   = 6'b000011,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI  = 6'b001000,
                         OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011,
                         OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI  = 6'b001110,
                         OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR = 6'b001000, FN_ADD = 6'b100000, FN_SUB = 6'b100010;

  state_t state_reg, state_next;

  logic       pc_en_c, ir_en_c, iord_c, mem_we_c, reg_we_c, ext_sign_c;
  logic [1:0] regdst_c, memtoreg_c, alusrca_c, alusrcb_c, pcsrc_c;
  logic [3:0] alucont_c;
  logic       r_known, r_shift, i_sign, trap;
  logic [3:0] r_alu, i_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= state_t'(RESET_STATE);
    else     state_reg <= state_next;
  end

  // R-type funct decode; r_known screens out functs this core does not implement
  always_comb begin
    r_known = 1'b1;
    r_shift = 1'b0;
    r_alu   = ALU_ADDU;
    case (bus.funct)
      6'b000000: begin r_alu = ALU_SLL; r_shift = 1'b1; end
      6'b000010: begin r_alu = ALU_SRL; r_shift = 1'b1; end
      6'b000011: begin r_alu = ALU_SRA; r_shift = 1'b1; end
      6'b100000: r_alu = ALU_ADD;
      6'b100001: r_alu = ALU_ADDU;
      6'b100010: r_alu = ALU_SUB;
      6'b100011: r_alu = ALU_SUBU;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100110: r_alu = ALU_XOR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      6'b101011: r_alu = ALU_SLTU;
      default:   r_known = 1'b0;
    endcase
  end

  always_comb begin
    i_alu  = ALU_ADDU;
    i_sign = 1'b1;
    case (bus.op)
      OP_ADDI:  i_alu = ALU_ADD;
      OP_ADDIU: i_alu = ALU_ADDU;
      OP_SLTI:  i_alu = ALU_SLT;
      OP_SLTIU: i_alu = ALU_SLTU;
      OP_ANDI:  begin i_alu = ALU_AND; i_sign = 1'b0; end
      OP_ORI:   begin i_alu = ALU_OR;  i_sign = 1'b0; end
      OP_XORI:  begin i_alu = ALU_XOR; i_sign = 1'b0; end
      OP_LUI:   begin i_alu = ALU_LUI; i_sign = 1'b0; end
      default:  ;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    pc_en_c    = 1'b0;
    ir_en_c    = 1'b0;
    iord_c     = 1'b0;
    mem_we_c   = 1'b0;
    reg_we_c   = 1'b0;
    regdst_c   = 2'b00;
    memtoreg_c = 2'b00;
    alusrca_c  = 2'b00;
    alusrcb_c  = 2'b00;
    ext_sign_c = 1'b0;
    alucont_c  = ALU_ADDU;
    pcsrc_c    = 2'b00;
    case (state_reg)
      S_FETCH: begin
        ir_en_c = 1'b1; pc_en_c = 1'b1; alusrcb_c = 2'b01;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_c = 2'b11; ext_sign_c = 1'b1;
        case (bus.op)
          OP_LW, OP_SW:         state_next = S_MEMADR;
          OP_RTYPE:             state_next = (bus.funct == FN_JR) ? S_JR :
                                             (r_known ? S_REXEC : S_FETCH);
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_next = S_IEXEC;
          OP_BEQ, OP_BNE:       state_next = S_BRANCH;
          OP_J:                 state_next = S_JUMP;
          OP_JAL:               state_next = S_JAL;
          default:              state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 2'b01; alusrcb_c = 2'b10; ext_sign_c = 1'b1;
        state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin iord_c = 1'b1; state_next = S_MEMWB; end
      S_MEMWB: begin reg_we_c = 1'b1; memtoreg_c = 2'b01; end
      S_MEMWR: begin iord_c = 1'b1; mem_we_c = 1'b1; end
      S_REXEC: begin
        alusrca_c = r_shift ? 2'b10 : 2'b01;
        alucont_c = r_alu;
        state_next = S_RWB;
      end
      S_RWB: begin reg_we_c = 1'b1; regdst_c = 2'b01; end
      S_IEXEC: begin
        alusrca_c = 2'b01; alusrcb_c = 2'b10;
        alucont_c = i_alu; ext_sign_c = i_sign;
        state_next = S_IWB;
      end
      S_IWB: reg_we_c = 1'b1;
      S_BRANCH: begin
        alusrca_c = 2'b01; alucont_c = ALU_SUBU; pcsrc_c = 2'b01;
        pc_en_c = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
      end
      S_JUMP: begin pcsrc_c = 2'b10; pc_en_c = 1'b1; end
      // PC already holds PC+4 here, so the link value is taken from it
      S_JAL: begin
        pcsrc_c = 2'b10; pc_en_c = 1'b1; reg_we_c = 1'b1;
        regdst_c = 2'b10; memtoreg_c = 2'b10;
      end
      S_JR: begin pcsrc_c = 2'b11; pc_en_c = 1'b1; end
      default: ;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf_reg;
  logic trap_class;

  // Flag captured at the end of the EXEC cycle; op/funct still held by IR in WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          ovf_reg <= 1'b0;
    else if (state_reg == S_REXEC || state_reg == S_IEXEC) ovf_reg <= bus.overflow;
  end

  assign trap_class = (bus.op == OP_ADDI) ||
                      (bus.op == OP_RTYPE && (bus.funct == FN_ADD || bus.funct == FN_SUB));
  assign trap = ovf_reg && trap_class && (state_reg == S_RWB || state_reg == S_IWB);
`else
  logic unused_overflow;
  assign unused_overflow = bus.overflow;
  assign trap = 1'b0;
`endif

  assign bus.pc_en    = pc_en_c & ~rst;
  assign bus.ir_en    = ir_en_c & ~rst;
  assign bus.mem_we   = mem_we_c & ~rst;
  assign bus.reg_we   = reg_we_c & ~trap & ~rst;
  assign bus.exc      = trap & ~rst;
  assign bus.iord     = iord_c;
  assign bus.regdst   = regdst_c;
  assign bus.memtoreg = memtoreg_c;
  assign bus.alusrca  = alusrca_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.ext_sign = ext_sign_c;
  assign bus.alucont  = alucont_c;
  assign bus.pcsrc    = pcsrc_c;
  assign bus.state    = state_reg;
endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each instruction pushes its per-cycle
// expected control words; a negedge monitor pops and compares.
module tb_mc_control;
  typedef struct packed {
    logic [3:0] state;
    logic       pc_en, ir_en, iord, mem_we, reg_we;
    logic [1:0] regdst, memtoreg, alusrca, alusrcb;
    logic       ext_sign;
    logic [3:0] alucont;
    logic [1:0] pcsrc;
    logic       exc;
  } outv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic check_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  outv_t exp_q[$];
  string tag_q[$];

  mc_control_if bus ();
  mc_control dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic outv_t mk(input int st, pc_en, ir_en, iord, mem_we, reg_we,
                               regdst, memtoreg, alusrca, alusrcb, ext_sign,
                               alucont, pcsrc, exc);
    outv_t v;
    v.state = st[3:0];       v.pc_en = pc_en[0];       v.ir_en = ir_en[0];
    v.iord = iord[0];        v.mem_we = mem_we[0];     v.reg_we = reg_we[0];
    v.regdst = regdst[1:0];  v.memtoreg = memtoreg[1:0];
    v.alusrca = alusrca[1:0]; v.alusrcb = alusrcb[1:0];
    v.ext_sign = ext_sign[0]; v.alucont = alucont[3:0];
    v.pcsrc = pcsrc[1:0];    v.exc = exc[0];
    return v;
  endfunction

  function automatic outv_t sample();
    outv_t v;
    v.state = bus.state;     v.pc_en = bus.pc_en;     v.ir_en = bus.ir_en;
    v.iord = bus.iord;       v.mem_we = bus.mem_we;   v.reg_we = bus.reg_we;
    v.regdst = bus.regdst;   v.memtoreg = bus.memtoreg;
    v.alusrca = bus.alusrca; v.alusrcb = bus.alusrcb;
    v.ext_sign = bus.ext_sign; v.alucont = bus.alucont;
    v.pcsrc = bus.pcsrc;     v.exc = bus.exc;
    return v;
  endfunction

  // Monitor: every enabled cycle must match the next queued expectation
  always @(negedge clk) begin
    if (check_en) begin
      outv_t act, e;
      string t;
      act = sample();
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_cycle: got %h (state %0d), required nothing queued", act, act.state);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL %s: got %h (state %0d), required %h (state %0d)", t, act, act.state, e, e.state);
        end
      end
    end
  end

  task automatic push(input string t, input outv_t v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic instr(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic ov, input int n);
    bus.op = o; bus.funct = f; bus.zero = z; bus.overflow = ov;
    $display("[TB] txn %s op=%b funct=%b zero=%b ovf=%b cycles=%0d", name, o, f, z, ov, n);
    go(n);
  endtask

  outv_t F, D;
  int trap_we, trap_exc;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    F = mk(0, 1,1,0,0,0, 0,0,0,1, 0, 4'b0000, 0, 0);
    D = mk(1, 0,0,0,0,0, 0,0,0,3, 1, 4'b0000, 0, 0);
`ifdef OVERFLOW_TRAP_EN
    trap_we = 0; trap_exc = 1;
`else
    trap_we = 1; trap_exc = 0;
`endif
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.overflow = 1'b0;

    go(2);
    chk("reset_state", {28'd0, bus.state}, 32'd0);
    chk("reset_enables", {28'd0, bus.pc_en, bus.ir_en, bus.mem_we, bus.reg_we}, 32'd0);
    chk("reset_exc", {31'd0, bus.exc}, 32'd0);
    rst = 1'b0;
    check_en = 1'b1;

    // lw: 0,1,2,3,4
    push("lw_fetch", F); push("lw_decode", D);
    push("lw_memadr", mk(2, 0,0,0,0,0, 0,0,1,2, 1, 4'b0000, 0, 0));
    push("lw_memrd",  mk(3, 0,0,1,0,0, 0,0,0,0, 0, 4'b0000, 0, 0));
    push("lw_memwb",  mk(4, 0,0,0,0,1, 0,1,0,0, 0, 4'b0000, 0, 0));
    instr("lw", 6'b100011, 6'd0, 1'b0, 1'b0, 5);

    // sw interrupted by reset in MEMWR
    push("sw_fetch", F); push("sw_decode", D);
    push("sw_memadr", mk(2, 0,0,0,0,0, 0,0,1,2, 1, 4'b0000, 0, 0));
    push("sw_memwr",  mk(5, 0,0,1,1,0, 0,0,0,0, 0, 4'b0000, 0, 0));
    instr("sw", 6'b101011, 6'd0, 1'b0, 1'b0, 3);
    @(negedge clk); #1;
    check_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_state", {28'd0, bus.state}, 32'd0);
    chk("async_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    go(1);
    chk("held_rst_state", {28'd0, bus.state}, 32'd0);
    chk("held_rst_enables", {28'd0, bus.pc_en, bus.ir_en, bus.mem_we, bus.reg_we}, 32'd0);
    rst = 1'b0;
    check_en = 1'b1;

    push("sra_fetch", F); push("sra_decode", D);
    push("sra_rexec", mk(6, 0,0,0,0,0, 0,0,2,0, 0, 4'b1100, 0, 0));
    push("sra_rwb",   mk(7, 0,0,0,0,1, 1,0,0,0, 0, 4'b0000, 0, 0));
    instr("sra", 6'b000000, 6'b000011, 1'b0, 1'b0, 4);

    push("add_ovf_fetch", F); push("add_ovf_decode", D);
    push("add_ovf_rexec", mk(6, 0,0,0,0,0, 0,0,1,0, 0, 4'b0010, 0, 0));
    push("add_ovf_rwb",   mk(7, 0,0,0,0,trap_we, 1,0,0,0, 0, 4'b0000, 0, trap_exc));
    instr("add_ovf", 6'b000000, 6'b100000, 1'b0, 1'b1, 4);

    push("addu_ovf_fetch", F); push("addu_ovf_decode", D);
    push("addu_ovf_rexec", mk(6, 0,0,0,0,0, 0,0,1,0, 0, 4'b0000, 0, 0));
    push("addu_ovf_rwb",   mk(7, 0,0,0,0,1, 1,0,0,0, 0, 4'b0000, 0, 0));
    instr("addu_ovf", 6'b000000, 6'b100001, 1'b0, 1'b1, 4);

    push("addi_ovf_fetch", F); push("addi_ovf_decode", D);
    push("addi_ovf_iexec", mk(8, 0,0,0,0,0, 0,0,1,2, 1, 4'b0010, 0, 0));
    push("addi_ovf_iwb",   mk(9, 0,0,0,0,trap_we, 0,0,0,0, 0, 4'b0000, 0, trap_exc));
    instr("addi_ovf", 6'b001000, 6'd0, 1'b0, 1'b1, 4);

    push("addi_fetch", F); push("addi_decode", D);
    push("addi_iexec", mk(8, 0,0,0,0,0, 0,0,1,2, 1, 4'b0010, 0, 0));
    push("addi_iwb",   mk(9, 0,0,0,0,1, 0,0,0,0, 0, 4'b0000, 0, 0));
    instr("addi", 6'b001000, 6'd0, 1'b0, 1'b0, 4);

    push("ori_fetch", F); push("ori_decode", D);
    push("ori_iexec", mk(8, 0,0,0,0,0, 0,0,1,2, 0, 4'b0100, 0, 0));
    push("ori_iwb",   mk(9, 0,0,0,0,1, 0,0,0,0, 0, 4'b0000, 0, 0));
    instr("ori", 6'b001101, 6'd0, 1'b0, 1'b0, 4);

    push("sltiu_fetch", F); push("sltiu_decode", D);
    push("sltiu_iexec", mk(8, 0,0,0,0,0, 0,0,1,2, 1, 4'b1000, 0, 0));
    push("sltiu_iwb",   mk(9, 0,0,0,0,1, 0,0,0,0, 0, 4'b0000, 0, 0));
    instr("sltiu", 6'b001011, 6'd0, 1'b0, 1'b0, 4);

    push("lui_fetch", F); push("lui_decode", D);
    push("lui_iexec", mk(8, 0,0,0,0,0, 0,0,1,2, 0, 4'b1101, 0, 0));
    push("lui_iwb",   mk(9, 0,0,0,0,1, 0,0,0,0, 0, 4'b0000, 0, 0));
    instr("lui", 6'b001111, 6'd0, 1'b0, 1'b0, 4);

    push("beq_t_fetch", F); push("beq_t_decode", D);
    push("beq_t_branch", mk(10, 1,0,0,0,0, 0,0,1,0, 0, 4'b0001, 1, 0));
    instr("beq_taken", 6'b000100, 6'd0, 1'b1, 1'b0, 3);

    push("beq_n_fetch", F); push("beq_n_decode", D);
    push("beq_n_branch", mk(10, 0,0,0,0,0, 0,0,1,0, 0, 4'b0001, 1, 0));
    instr("beq_not", 6'b000100, 6'd0, 1'b0, 1'b0, 3);

    push("bne_n_fetch", F); push("bne_n_decode", D);
    push("bne_n_branch", mk(10, 0,0,0,0,0, 0,0,1,0, 0, 4'b0001, 1, 0));
    instr("bne_not", 6'b000101, 6'd0, 1'b1, 1'b0, 3);

    push("bne_t_fetch", F); push("bne_t_decode", D);
    push("bne_t_branch", mk(10, 1,0,0,0,0, 0,0,1,0, 0, 4'b0001, 1, 0));
    instr("bne_taken", 6'b000101, 6'd0, 1'b0, 1'b0, 3);

    push("j_fetch", F); push("j_decode", D);
    push("j_jump", mk(11, 1,0,0,0,0, 0,0,0,0, 0, 4'b0000, 2, 0));
    instr("j", 6'b000010, 6'd0, 1'b0, 1'b0, 3);

    push("jal_fetch", F); push("jal_decode", D);
    push("jal_jal", mk(12, 1,0,0,0,1, 2,2,0,0, 0, 4'b0000, 2, 0));
    instr("jal", 6'b000011, 6'd0, 1'b0, 1'b0, 3);

    push("jr_fetch", F); push("jr_decode", D);
    push("jr_jr", mk(13, 1,0,0,0,0, 0,0,0,0, 0, 4'b0000, 3, 0));
    instr("jr", 6'b000000, 6'b001000, 1'b0, 1'b0, 3);

    push("badop_fetch", F); push("badop_decode", D);
    instr("bad_op", 6'b111111, 6'd0, 1'b0, 1'b0, 2);

    push("badfn_fetch", F); push("badfn_decode", D);
    instr("bad_funct", 6'b000000, 6'b111111, 1'b0, 1'b0, 2);

    // Back in FETCH with nothing pending
    check_en = 1'b0;
    chk("end_state_fetch", {28'd0, bus.state}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle MIPS control FSM: the controlling end of the multi-cycle datapath (PC/IR/MDR/ALUOut registers, regfile, ALU, operand muxes, sign/zero extender).
- Each cycle it reads the latched instruction opcode/funct and the ALU flags, then drives every enable, mux select and ALU opcode for that cycle.
- One instance per CPU core. It sits between the instruction register and the datapath select/enable inputs.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-overflow flag
- pc_en  out  1  PC register load
- ir_en  out  1  instruction register load
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_we  out  1  data memory write
- reg_we  out  1  regfile write enable
- regdst  out  2  write address: 00 = rt, 01 = rd, 10 = r31
- memtoreg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
- alusrca  out  2  ALU A: 00 = PC, 01 = reg A, 10 = zero-extended shamt
- alusrcb  out  2  ALU B: 00 = reg B, 01 = 32'd4, 10 = ext imm, 11 = ext imm<<2
- ext_sign  out  1  extender mode: 1 = sign, 0 = zero
- alucont  out  4  ALU opcode: ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, OR 0100, AND 0101, XOR 0110, NOR 0111, SLTU 1000, SLT 1001, SLL 1010, SRL 1011, SRA 1100, LUI 1101
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump addr, 11 = reg A
- state  out  4  current state (debug)
- exc  out  1  overflow-trap pulse (OVERFLOW_TRAP_EN only, otherwise tied 0)

Behaviour:
- Output timing and defaults:
  - Moore outputs decoded from state. Exceptions: alucont/alusrca/ext_sign also decode op/funct in EXEC states, and pc_en in BRANCH depends on zero.
  - Any output not listed for a state is 0.
- Reset:
  - rst high → state = FETCH immediately.
  - While rst is high, pc_en, ir_en, mem_we and reg_we are forced to 0 and exc = 0.
  - Reset mid-instruction abandons the instruction with no further writes.
- States:
  - FETCH (0): ir_en=1, pc_en=1, iord=0, alusrca=00, alusrcb=01, ADDU, pcsrc=00. Next: DECODE.
  - DECODE (1): alusrca=00, alusrcb=11, ext_sign=1, ADDU (branch target → ALUOut). Next state by op:
    - lw/sw → MEMADR
    - op 000000 → JR if funct=001000; REXEC if funct is a listed R-type; else FETCH
    - addi/addiu/slti/sltiu/andi/ori/xori/lui → IEXEC
    - beq/bne → BRANCH
    - j → JUMP
    - jal → JAL
    - any other op → FETCH (no-op, no writes)
  - MEMADR (2): alusrca=01, alusrcb=10, ext_sign=1, ADDU. Next: lw→MEMRD, sw→MEMWR.
  - MEMRD (3): iord=1. Next: MEMWB.
  - MEMWB (4): reg_we=1, regdst=00, memtoreg=01. Next: FETCH.
  - MEMWR (5): iord=1, mem_we=1. Next: FETCH.
  - REXEC (6): alusrcb=00.
    - alusrca=10 for sll/srl/sra, else 01.
    - funct→alucont: 000000 SLL, 000010 SRL, 000011 SRA, 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU.
    - Next: RWB.
  - RWB (7): reg_we=1, regdst=01, memtoreg=00. Next: FETCH.
  - IEXEC (8): alusrca=01, alusrcb=10.
    - op→alucont: addi ADD, addiu ADDU, slti SLT, sltiu SLTU, andi AND, ori OR, xori XOR, lui LUI.
    - ext_sign=1 for addi/addiu/slti/sltiu, 0 for andi/ori/xori/lui.
    - Next: IWB.
  - IWB (9): reg_we=1, regdst=00, memtoreg=00. Next: FETCH.
  - BRANCH (10): alusrca=01, alusrcb=00, SUBU, pcsrc=01.
    - pc_en = zero for beq, ~zero for bne.
    - Next: FETCH.
  - JUMP (11): pcsrc=10, pc_en=1. Next: FETCH.
  - JAL (12): pcsrc=10, pc_en=1, reg_we=1, regdst=10, memtoreg=10 (PC already holds PC+4 and is written before the PC update). Next: FETCH.
  - JR (13): pcsrc=11, pc_en=1. Next: FETCH.
  - Encodings 14–15: → FETCH, no writes.
- Latency in cycles including FETCH:
  - lw 5; sw, R-type, I-type 4; beq, bne, j, jal, jr 3; unknown op 2.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN.
- Defined:
  - In RWB/IWB for add/sub/addi, if the overflow flag registered at the end of the EXEC cycle is 1, reg_we=0 and exc=1 for that single cycle.
  - Next state is still FETCH; the PC is not altered.
- Undefined: overflow is ignored, the write always occurs, exc is constant 0.

Test Plan:
- rst pulse mid-MEMWR → state=0 asynchronously; mem_we=0 throughout reset; first cycle after release is FETCH with ir_en=1, pc_en=1.
- op=100011 (lw) → state sequence 0,1,2,3,4,0; MEMWB has reg_we=1, regdst=00, memtoreg=01; iord=1 only in state 3.
- op=0, funct=000011 (sra) → REXEC alusrca=10, alucont=1100; RWB regdst=01; 4 cycles total.
- op=000100 (beq): zero=1 → pc_en=1, pcsrc=01 in BRANCH; zero=0 → pc_en=0. op=000101 (bne) gives the inverse.
- op=000011 (jal) → JAL: reg_we=1, regdst=10, memtoreg=10, pcsrc=10, pc_en=1; 3 cycles. op=111111 → 0,1,0 with no enables asserted.
- OVERFLOW_TRAP_EN defined, addi with overflow=1 in IEXEC → IWB reg_we=0, exc=1 for one cycle. Macro undefined → reg_we=1, exc=0.
